// File: rtl/dadda_mul_arb.sv
// dadda_mul_arb: round-robin controller sharing one external combinational
// 8x8 unsigned multiplier (partial products + Dadda tree) between two
// requesters. A granted operand pair is registered onto mul_a/mul_b, the
// product on mul_p is sampled LAT cycles later and held on a valid/ready
// result port tagged with the requester id.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reqN_v/a/b/rdy      requester N operand pair and accept strobe (N=0,1)
//   mul_a, mul_b        registered operands to the shared multiplier
//   mul_p               product from the shared multiplier
//   res_v/p/id/rdy      result valid, product, requester id, consumer ready
//   cnt_clr, gnt0_cnt, gnt1_cnt
//                       saturating grant counters, present only when
//                       DADDA_MUL_ARB_STATS_EN is defined
//
// Parameters: LAT (1..15) settle cycles, CNT_W grant counter width.
module dadda_mul_arb #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DADDA_MUL_ARB_STATS_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  gnt0_cnt,
  output logic [CNT_W-1:0]  gnt1_cnt,
`endif
  input  logic              req0_v,
  input  logic [7:0]        req0_a,
  input  logic [7:0]        req0_b,
  output logic              req0_rdy,
  input  logic              req1_v,
  input  logic [7:0]        req1_a,
  input  logic [7:0]        req1_b,
  output logic              req1_rdy,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_p,
  output logic              res_v,
  output logic [15:0]       res_p,
  output logic              res_id,
  input  logic              res_rdy
);

  if (LAT < 1 || LAT > 15 || CNT_W < 1) begin : g_bad_param
    $error("dadda_mul_arb: LAT must be 1..15 and CNT_W at least 1");
  end

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       last_gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Tie goes to the requester that was not granted last; last_gnt resets to
  // 1 so requester 0 wins the first tie.
  always_comb begin
    state_nxt = state;
    req0_rdy  = 1'b0;
    req1_rdy  = 1'b0;
    case (state)
      IDLE: begin
        if (req0_v && (!req1_v || last_gnt)) begin
          req0_rdy  = 1'b1;
          state_nxt = WAIT;
        end else if (req1_v) begin
          req1_rdy  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (wait_cnt == 4'd1) state_nxt = DONE;
      DONE:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign res_v = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a    <= '0;
      mul_b    <= '0;
      res_p    <= '0;
      res_id   <= 1'b0;
      wait_cnt <= '0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_rdy || req1_rdy) begin
            mul_a    <= req1_rdy ? req1_a : req0_a;
            mul_b    <= req1_rdy ? req1_b : req0_b;
            res_id   <= req1_rdy;
            last_gnt <= req1_rdy;
            wait_cnt <= LAT_CNT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) res_p <= mul_p;
        end
        default: ;
      endcase
    end
  end

`ifdef DADDA_MUL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (req0_v && req0_rdy && gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + CNT_W'(1);
      if (req1_v && req1_rdy && gnt1_cnt != '1) gnt1_cnt <= gnt1_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
